piccolo80_iter_ctrl: RTL and testbench

Iterative Piccolo-80 encryption controller. It sequences the team's single-round Piccolo datapath (piccoloenc, combinational, 64-bit state, 32-bit round-key pair, 5-bit round index), with exactly one round per clock. It owns the following:
- valid/ready input and output handshakes
- key and whitening-key registers
- the mod-5 round-key schedule
- the round counter
- removal of the round permutation after the final round
- post-whitening

The datapath is external and connects through the dp_* ports.

---
 rtl/piccolo_pkg.sv | 47 ++++
 rtl/piccolo80_iter_ctrl_if.sv | 29 ++
 rtl/piccolo80_ksched.sv | 37 +++
 rtl/piccolo80_iter_ctrl.sv | 101 ++++++++++
 tb/tb_piccolo80_iter_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piccolo_pkg.sv
// Shared types, widths and block-level helpers for the iterative Piccolo-80 controller.
package piccolo_pkg;

  localparam int ROUNDS_DEF = 25;
  localparam int BLK        = 64;
  localparam int KEY        = 80;
  localparam int RK         = 32;
  localparam int RIDX       = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Key word i (0..4); K0 occupies the most significant 16 bits.
  function automatic logic [15:0] kword(input logic [KEY-1:0] k, input int unsigned i);
    return k[KEY-1-16*i -: 16];
  endfunction

  // Inverse of the datapath byte permutation: u = {c6,c3,c0,c5,c2,c7,c4,c1}.
  function automatic logic [BLK-1:0] inv_rp(input logic [BLK-1:0] c);
    return {c[15:8], c[39:32], c[63:56], c[23:16],
            c[47:40], c[7:0],  c[31:24], c[55:48]};
  endfunction

  function automatic logic [BLK-1:0] whiten_pre(input logic [BLK-1:0] x,
                                                input logic [KEY-1:0] k);
    logic [15:0] k0, k1, wk0, wk1;
    k0  = kword(k, 0);
    k1  = kword(k, 1);
    wk0 = {k0[15:8], k1[7:0]};
    wk1 = {k1[15:8], k0[7:0]};
    return {x[63:48] ^ wk0, x[47:32], x[31:16] ^ wk1, x[15:0]};
  endfunction

  function automatic logic [BLK-1:0] whiten_post(input logic [BLK-1:0] x,
                                                 input logic [KEY-1:0] k);
    logic [15:0] k3, k4, wk2, wk3;
    k3  = kword(k, 3);
    k4  = kword(k, 4);
    wk2 = {k4[15:8], k3[7:0]};
    wk3 = {k3[15:8], k4[7:0]};
    return {x[63:48] ^ wk2, x[47:32], x[31:16] ^ wk3, x[15:0]};
  endfunction

endpackage

// File: rtl/piccolo80_iter_ctrl_if.sv
// Handshake and datapath bundle between the Piccolo-80 controller and its environment.
interface piccolo80_iter_ctrl_if;
  import piccolo_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [KEY-1:0]  key;
  logic [BLK-1:0]  pt;
  logic            out_valid;
  logic            out_ready;
  logic [BLK-1:0]  ct;
  logic            busy;
  logic [RIDX-1:0] dp_round;
  logic [RK-1:0]   dp_rk;
  logic [BLK-1:0]  dp_state;
  logic [BLK-1:0]  dp_result;

  // Environment side: producer, consumer and the combinational round datapath.
  modport master (
    output in_valid, key, pt, out_ready, dp_result,
    input  in_ready, out_valid, ct, busy, dp_round, dp_rk, dp_state
  );

  // Controller side.
  modport slave (
    input  in_valid, key, pt, out_ready, dp_result,
    output in_ready, out_valid, ct, busy, dp_round, dp_rk, dp_state
  );
endinterface

// File: rtl/piccolo80_ksched.sv
// Piccolo-80 round-key selector: latched master key plus a mod-5 phase counter.
module piccolo80_ksched
  import piccolo_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [KEY-1:0] key_in,
  output logic [KEY-1:0] key_q,
  output logic [RK-1:0]  rk
);

  logic [2:0] m5_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      m5_q  <= '0;
    end else if (load) begin
      key_q <= key_in;
      m5_q  <= '0;
    end else if (step) begin
      m5_q  <= (m5_q == 3'd4) ? 3'd0 : m5_q + 3'd1;
    end
  end

  always_comb begin
    rk = {kword(key_q, 2), kword(key_q, 3)};
    case (m5_q)
      3'd1, 3'd4: rk = {kword(key_q, 0), kword(key_q, 1)};
      3'd3:       rk = {kword(key_q, 4), kword(key_q, 4)};
      default:    rk = {kword(key_q, 2), kword(key_q, 3)};
    endcase
  end

endmodule

// File: rtl/piccolo80_iter_ctrl.sv
// Iterative Piccolo-80 controller driving an external one-round datapath, one round per clock.
// Optional macro PICCOLO_ABORT_EN adds an abort input that cancels a block in RUN or DONE.
module piccolo80_iter_ctrl
  import piccolo_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic clk,
  input  logic rst_n,
`ifdef PICCOLO_ABORT_EN
  input  logic abort,
`endif
  piccolo80_iter_ctrl_if.slave bus
);

  localparam logic [RIDX-1:0] LAST_RND = RIDX'(ROUNDS - 1);

  fsm_t            state_q, state_d;
  logic [BLK-1:0]  blk_q;
  logic [BLK-1:0]  ct_q;
  logic [RIDX-1:0] rnd_q;
  logic [KEY-1:0]  key_q;
  logic [RK-1:0]   rk;
  logic            accept, step, last, abort_w;

`ifdef PICCOLO_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        // Abort wins over a simultaneous offer so nothing is accepted that edge.
        if (bus.in_valid && !abort_w) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_w) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (rnd_q == LAST_RND) begin
            last    = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (abort_w || bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      blk_q   <= '0;
      rnd_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        blk_q <= whiten_pre(bus.pt, bus.key);
        rnd_q <= '0;
      end else if (step) begin
        rnd_q <= rnd_q + 1'b1;
        if (!last) blk_q <= bus.dp_result;
      end
      // The datapath always applies the byte permutation; the last round must not have it.
      if (last) ct_q <= whiten_post(inv_rp(bus.dp_result), key_q);
    end
  end

  piccolo80_ksched u_ksched (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (step),
    .key_in (bus.key),
    .key_q  (key_q),
    .rk     (rk)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.ct        = ct_q;
  assign bus.dp_round  = rnd_q;
  assign bus.dp_rk     = rk;
  assign bus.dp_state  = blk_q;

endmodule

// File: tb/tb_piccolo80_iter_ctrl.sv
// Bench for piccolo80_iter_ctrl: behavioural Piccolo-80 model, per-cycle compare, directed scenarios.
module tb_piccolo80_iter_ctrl;

  localparam int ROUNDS = 25;
  localparam logic [79:0] KEY_KAT = 80'h00112233445566778899;
  localparam logic [63:0] PT_KAT  = 64'h0123456789abcdef;
  localparam logic [63:0] CT_KAT  = 64'h8d2bff9935f84056;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ab;
  int   checks = 0;
  int   failures = 0;

  piccolo80_iter_ctrl_if bus();

`ifdef PICCOLO_ABORT_EN
  logic abort = 1'b0;
  assign ab = abort;
  piccolo80_iter_ctrl #(.ROUNDS(ROUNDS)) dut (.clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus));
`else
  assign ab = 1'b0;
  piccolo80_iter_ctrl #(.ROUNDS(ROUNDS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  // ---------------- Piccolo-80 reference ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'he; 4'h1: sb = 4'h4; 4'h2: sb = 4'hb; 4'h3: sb = 4'h2;
      4'h4: sb = 4'h3; 4'h5: sb = 4'h8; 4'h6: sb = 4'h0; 4'h7: sb = 4'h9;
      4'h8: sb = 4'h1; 4'h9: sb = 4'ha; 4'ha: sb = 4'h7; 4'hb: sb = 4'hf;
      4'hc: sb = 4'h6; 4'hd: sb = 4'hc; 4'he: sb = 4'h5; default: sb = 4'hd;
    endcase
  endfunction

  function automatic logic [3:0] x2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [15:0] ff(input logic [15:0] x);
    logic [3:0] s0, s1, s2, s3, y0, y1, y2, y3;
    s0 = sb(x[15:12]); s1 = sb(x[11:8]); s2 = sb(x[7:4]); s3 = sb(x[3:0]);
    y0 = x2(s0) ^ x2(s1) ^ s1 ^ s2 ^ s3;
    y1 = s0 ^ x2(s1) ^ x2(s2) ^ s2 ^ s3;
    y2 = s0 ^ s1 ^ x2(s2) ^ x2(s3) ^ s3;
    y3 = x2(s0) ^ s0 ^ s1 ^ s2 ^ x2(s3);
    return {sb(y0), sb(y1), sb(y2), sb(y3)};
  endfunction

  function automatic logic [31:0] con(input int i);
    logic [4:0] c;
    c = 5'(i + 1);
    return {c, 5'd0, c, 2'b00, c, 5'd0, c} ^ 32'h0f1e2d3c;
  endfunction

  function automatic logic [31:0] rkraw(input logic [79:0] k, input int i);
    case (i % 5)
      1, 4:    return k[79:48];
      3:       return {k[15:0], k[15:0]};
      default: return k[47:16];
    endcase
  endfunction

  function automatic logic [63:0] round_core(input logic [63:0] x, input int i, input logic [31:0] rkr);
    logic [31:0] rk;
    rk = rkr ^ con(i);
    return {x[63:48], x[47:32] ^ ff(x[63:48]) ^ rk[31:16],
            x[31:16], x[15:0]  ^ ff(x[31:16]) ^ rk[15:0]};
  endfunction

  function automatic logic [63:0] rp(input logic [63:0] y);
    return {y[47:40], y[7:0], y[31:24], y[55:48], y[15:8], y[39:32], y[63:56], y[23:16]};
  endfunction

  function automatic logic [63:0] wpre(input logic [79:0] k, input logic [63:0] p);
    return {p[63:48] ^ {k[79:72], k[55:48]}, p[47:32], p[31:16] ^ {k[63:56], k[71:64]}, p[15:0]};
  endfunction

  function automatic logic [63:0] piccolo_enc(input logic [79:0] k, input logic [63:0] p);
    logic [63:0] x;
    x = wpre(k, p);
    for (int i = 0; i < ROUNDS - 1; i++) x = rp(round_core(x, i, rkraw(k, i)));
    x = round_core(x, ROUNDS - 1, rkraw(k, ROUNDS - 1));
    return {x[63:48] ^ {k[15:8], k[23:16]}, x[47:32], x[31:16] ^ {k[31:24], k[7:0]}, x[15:0]};
  endfunction

  // External one-round datapath: round function followed by the byte permutation.
  always_comb bus.dp_result = rp(round_core(bus.dp_state, int'(bus.dp_round), bus.dp_rk));

  // ---------------- Transaction-level model ----------------
  int          m_phase = 0;   // 0 idle, 1 running, 2 holding result
  int          m_cnt = 0;
  int          cyc = 0;
  int          ov_seen = 0;
  logic [79:0] m_key = '0;
  logic [63:0] m_ctexp = '0;
  logic [63:0] m_ctreg = '0;
  logic [63:0] m_st [ROUNDS+1];
  int          acc_q [$];
  logic [63:0] dlv_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_ctreg = '0;
    end else begin
      cyc++;
      case (m_phase)
        0: if (bus.in_valid && !ab) begin
             m_phase = 1; m_cnt = 0; m_key = bus.key;
             m_ctexp = piccolo_enc(bus.key, bus.pt);
             m_st[0] = wpre(bus.key, bus.pt);
             for (int i = 0; i < ROUNDS; i++) m_st[i+1] = rp(round_core(m_st[i], i, rkraw(m_key, i)));
             acc_q.push_back(cyc);
           end
        1: if (ab) m_phase = 0;
           else begin
             m_cnt++;
             if (m_cnt == ROUNDS) begin m_phase = 2; m_ctreg = m_ctexp; end
           end
        default: if (ab) m_phase = 0;
                 else if (bus.out_ready) begin dlv_q.push_back(m_ctreg); m_phase = 0; end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.out_valid) ov_seen++;
    chk("in_ready", 64'(bus.in_ready), 64'(m_phase == 0));
    chk("busy", 64'(bus.busy), 64'(m_phase == 1));
    chk("out_valid", 64'(bus.out_valid), 64'(m_phase == 2));
    chk("ct", bus.ct, m_ctreg);
    if (m_phase == 1) begin
      chk("dp_round", 64'(bus.dp_round), 64'(m_cnt));
      chk("dp_rk", 64'(bus.dp_rk), 64'(rkraw(m_key, m_cnt)));
      chk("dp_state", bus.dp_state, m_st[m_cnt]);
    end
  end

  // ---------------- Directed stimulus ----------------
  task automatic start_block(input logic [79:0] k, input logic [63:0] p);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.key = k; bus.pt = p;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_ct"}, bus.ct, 64'd0);
    chk({tag, "_dp_round"}, 64'(bus.dp_round), 64'd0);
    chk({tag, "_dp_rk"}, 64'(bus.dp_rk), 64'd0);
    chk({tag, "_dp_state"}, bus.dp_state, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int edges, n0, d0, ov0;
    logic [79:0] k;
    logic [63:0] p;
    bus.in_valid = 1'b0; bus.key = '0; bus.pt = '0; bus.out_ready = 1'b0;
    #1;
    chk_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Model pins.
    chk("model_kat", piccolo_enc(KEY_KAT, PT_KAT), CT_KAT);
    chk("model_rk3", 64'(rkraw(KEY_KAT, 3)), 64'h88998899);
    chk("model_rk4", 64'(rkraw(KEY_KAT, 4)), 64'h00112233);
    chk("model_rk5", 64'(rkraw(KEY_KAT, 5)), 64'h44556677);

    // KAT with schedule probes, ignored mid-run offer, then backpressure.
    start_block(KEY_KAT, PT_KAT);
    chk("rk_rnd0", 64'(bus.dp_rk), 64'h44556677);
    edges = 0;
    while (!bus.out_valid && edges < 60) begin
      @(posedge clk); #1; edges++;
      if (edges == 3) begin
        chk("rnd3", 64'(bus.dp_round), 64'd3);
        chk("rk_rnd3", 64'(bus.dp_rk), 64'h88998899);
      end
      if (edges == 4) chk("rk_rnd4", 64'(bus.dp_rk), 64'h00112233);
      if (edges == 5) chk("rk_rnd5", 64'(bus.dp_rk), 64'h44556677);
      if (edges == 10) begin bus.in_valid = 1'b1; bus.key = ~KEY_KAT; bus.pt = ~PT_KAT; end
      if (edges == 11) bus.in_valid = 1'b0;
    end
    chk("latency", 64'(edges), 64'd25);
    chk("kat_ct", bus.ct, CT_KAT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_ct", bus.ct, CT_KAT);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("release_out_valid", 64'(bus.out_valid), 64'd0);

    // Back-to-back KAT blocks.
    n0 = acc_q.size(); d0 = dlv_q.size();
    @(negedge clk); bus.in_valid = 1'b1; bus.key = KEY_KAT; bus.pt = PT_KAT;
    edges = 0;
    while (acc_q.size() < n0 + 2 && edges < 100) begin @(posedge clk); #1; edges++; end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", 64'(acc_q.size()), 64'(n0 + 2));
    if (acc_q.size() >= n0 + 2) chk("b2b_gap", 64'(acc_q[n0+1] - acc_q[n0]), 64'd27);
    edges = 0;
    while (dlv_q.size() < d0 + 2 && edges < 100) begin @(posedge clk); #1; edges++; end
    chk("b2b_count", 64'(dlv_q.size()), 64'(d0 + 2));
    if (dlv_q.size() >= d0 + 2) begin
      chk("b2b_ct0", dlv_q[d0], CT_KAT);
      chk("b2b_ct1", dlv_q[d0+1], CT_KAT);
    end

    // Further key/plaintext patterns against the reference cipher.
    for (int t = 0; t < 3; t++) begin
      k = {$urandom(), $urandom(), 16'($urandom())};
      p = {$urandom(), $urandom()};
      if (t == 0) begin k = '1; p = '0; end
      d0 = dlv_q.size();
      start_block(k, p);
      edges = 0;
      while (dlv_q.size() < d0 + 1 && edges < 60) begin @(posedge clk); #1; edges++; end
      chk("vec_count", 64'(dlv_q.size()), 64'(d0 + 1));
      if (dlv_q.size() > d0) chk("vec_ct", dlv_q[d0], piccolo_enc(k, p));
    end

    // Reset in the middle of a block.
    start_block(KEY_KAT, PT_KAT);
    edges = 0;
    while (int'(bus.dp_round) != 12 && edges < 40) begin @(posedge clk); #1; edges++; end
    chk("reached_rnd12", 64'(bus.dp_round), 64'd12);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("midreset");
    ov0 = ov_seen;
    @(negedge clk); rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 chk("midreset_no_output", 64'(ov_seen), 64'(ov0));

`ifdef PICCOLO_ABORT_EN
    // Abort during RUN, abort against an offer in IDLE, then a clean block.
    start_block(KEY_KAT, PT_KAT);
    edges = 0;
    while (int'(bus.dp_round) != 7 && edges < 40) begin @(posedge clk); #1; edges++; end
    ov0 = ov_seen;
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    @(negedge clk); abort = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1; abort = 1'b0; bus.in_valid = 1'b0;
    chk("abort_idle_no_accept", 64'(bus.busy), 64'd0);
    repeat (30) @(posedge clk);
    #1 chk("abort_no_output", 64'(ov_seen), 64'(ov0));
    d0 = dlv_q.size();
    start_block(KEY_KAT, PT_KAT);
    edges = 0;
    while (!bus.out_valid && edges < 60) begin @(posedge clk); #1; edges++; end
    chk("abort_after_ct", bus.ct, CT_KAT);
    @(posedge clk); #1;
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
